// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
//   Shared definitions for the shift arbiter/sequencer:
//     - default operand width and shift-amount width
//     - shift-type encodings carried on reqN_type
//     - FSM state encoding of the sequencer
// -----------------------------------------------------------------------------
package shift_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SHW   = 5;

    // Shift-type encodings
    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
//   Combinational shift of a WIDTH-bit value by 0..STEP positions.
//   With STEP = WIDTH it acts as a full barrel shifter (used when the top is
//   built with SHIFT_BARREL_EN).
//
// Ports:
//   operand  in  WIDTH               value to shift
//   op       in  2                   SH_LSL / SH_LSR / SH_ASR / SH_ROR
//   amt      in  $clog2(STEP+1)      positions to shift, 0..STEP
//   result   out WIDTH               shifted value
// -----------------------------------------------------------------------------
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0]             operand,
    input  logic [1:0]                   op,
    input  logic [$clog2(STEP+1)-1:0]    amt,
    output logic [WIDTH-1:0]             result
);

    // Wide enough to hold WIDTH itself, so the rotate complement WIDTH-amt
    // is exact even for amt = 0.
    localparam int LW = $clog2(WIDTH) + 1;

    logic [LW-1:0] amt_ext;
    logic [LW-1:0] wrap;

    // NOTE: every variable written here gets a value on every path, so no
    // latch is inferred.
    always_comb begin
        amt_ext = LW'(amt);
        wrap    = LW'(WIDTH) - amt_ext;
        case (op)
            SH_LSL:  result = operand << amt;
            SH_LSR:  result = operand >> amt;
            // Arithmetic shift replicates the MSB; after any number of steps
            // the MSB is still the original one.
            SH_ASR:  result = $signed(operand) >>> amt;
            // Shifting left by WIDTH yields 0, so amt = 0 degrades cleanly
            // to the plain operand.
            SH_ROR:  result = (operand >> amt) | (operand << wrap);
            default: result = operand;
        endcase
    end

endmodule

// File: rtl/shift_arbiter_seq.sv
// -----------------------------------------------------------------------------
// shift_arbiter_seq
//   Shares one iterative shifter between two requesters. Round-robin grant in
//   IDLE, STEP positions per cycle in SHIFT, result held in DONE until taken.
//
//   Build option: SHIFT_BARREL_EN
//     defined   - SHIFT lasts exactly one cycle (full barrel shift, STEP ignored)
//     undefined - iterative shift, min(STEP, remaining) positions per cycle
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req0_valid/ready/type/amt/data   requester 0 (execute stage)
//   req1_valid/ready/type/amt/data   requester 1 (mul/div helper path)
//     reqN_ready is combinational, high for one cycle on accept in IDLE
//   rsp_valid, rsp_ready             result handshake
//   rsp_id                           index of the requester owning rsp_data
//   rsp_data                         shifted result
//   busy                             high in SHIFT and DONE
// -----------------------------------------------------------------------------
module shift_arbiter_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEP  = 1,
    parameter int SHW   = DEF_SHW
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_type,
    input  logic [SHW-1:0]   req0_amt,
    input  logic [WIDTH-1:0] req0_data,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_type,
    input  logic [SHW-1:0]   req1_amt,
    input  logic [WIDTH-1:0] req1_data,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

`ifdef SHIFT_BARREL_EN
    localparam int EFF_STEP = WIDTH;
`else
    localparam int EFF_STEP = STEP;
`endif
    localparam int AW = $clog2(EFF_STEP + 1);
    // One bit wider than the amount so EFF_STEP (up to WIDTH) fits alongside it.
    localparam int CW = SHW + 1;

    state_t           state;
    state_t           state_next;

    logic [1:0]       op_q;
    logic [SHW-1:0]   remaining_q;
    logic [WIDTH-1:0] data_q;
    logic             id_q;
    logic             rr_ptr_q;     // 0: requester 0 wins a tie, 1: requester 1

    logic             any_valid;
    logic             gnt_id;
    logic             accept;
    logic [1:0]       sel_type;
    logic [SHW-1:0]   sel_amt;
    logic [WIDTH-1:0] sel_data;

    logic [CW-1:0]    k_ext;
    logic [AW-1:0]    k;
    logic [SHW-1:0]   remaining_after;
    logic [WIDTH-1:0] stepped;

    // -------------------------------------------------------------------------
    // Arbitration: a lone requester always wins; a tie goes to the pointer.
    // -------------------------------------------------------------------------
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            gnt_id = rr_ptr_q;
        end else begin
            gnt_id = req1_valid;
        end
        sel_type = gnt_id ? req1_type : req0_type;
        sel_amt  = gnt_id ? req1_amt  : req0_amt;
        sel_data = gnt_id ? req1_data : req0_data;
    end

    // -------------------------------------------------------------------------
    // Step size for this cycle: k = min(EFF_STEP, remaining).
    // In barrel mode EFF_STEP = WIDTH > any amount, so k = remaining and SHIFT
    // completes in one cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        if (CW'(remaining_q) > CW'(EFF_STEP)) begin
            k_ext = CW'(EFF_STEP);
        end else begin
            k_ext = CW'(remaining_q);
        end
        k               = AW'(k_ext);
        remaining_after = remaining_q - SHW'(k_ext);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (EFF_STEP)
    ) u_step (
        .operand (data_q),
        .op      (op_q),
        .amt     (k),
        .result  (stepped)
    );

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and request handshake
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                // Ready is held off during reset so no one sees a false accept.
                if (any_valid && !rst) begin
                    accept     = 1'b1;
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    state_next = (sel_amt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (remaining_after == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Handshake cycle returns to IDLE; the next accept is one
                // cycle later because ready only asserts in IDLE.
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Operation registers
    // -------------------------------------------------------------------------
    // NOTE: the datapath registers are reset as well, because rsp_data and
    // rsp_id are driven straight from them and must read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= SH_LSL;
            remaining_q <= '0;
            data_q      <= '0;
            id_q        <= 1'b0;
            rr_ptr_q    <= 1'b0;
        end else if (accept) begin
            op_q        <= sel_type;
            remaining_q <= sel_amt;
            data_q      <= sel_data;
            id_q        <= gnt_id;
            rr_ptr_q    <= ~gnt_id;
        end else if (state == ST_SHIFT) begin
            data_q      <= stepped;
            remaining_q <= remaining_after;
        end
    end

    // -------------------------------------------------------------------------
    // Response side
    // -------------------------------------------------------------------------
    assign rsp_valid = (state == ST_DONE);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_shift_arbiter_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter_seq
//   Self-checking bench for shift_arbiter_seq. A transaction-level model
//   (grant rule, bit-by-bit shift, latency countdown) predicts every output
//   each cycle; directed sequences pin the model with literal expectations.
//   A second instance with STEP=4 covers the multi-bit step.
//   Honours SHIFT_BARREL_EN for the expected latencies.
// -----------------------------------------------------------------------------
module tb_shift_arbiter_seq;
    import shift_pkg::*;

    localparam int WIDTH   = 32;
    localparam int SHW     = 5;
    localparam int TB_STEP = 1;
`ifdef SHIFT_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;

    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_type, req1_type;
    logic [4:0]  req0_amt, req1_amt;
    logic [31:0] req0_data, req1_data;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0] rsp_data;

    logic        q_req0_valid, q_req0_ready, q_req1_valid, q_req1_ready;
    logic [1:0]  q_req0_type, q_req1_type;
    logic [4:0]  q_req0_amt, q_req1_amt;
    logic [31:0] q_req0_data, q_req1_data;
    logic        q_rsp_valid, q_rsp_ready, q_rsp_id, q_busy;
    logic [31:0] q_rsp_data;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    shift_arbiter_seq #(.WIDTH(WIDTH), .STEP(TB_STEP), .SHW(SHW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_type(req0_type),
        .req0_amt(req0_amt), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_type(req1_type),
        .req1_amt(req1_amt), .req1_data(req1_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    shift_arbiter_seq #(.WIDTH(WIDTH), .STEP(4), .SHW(SHW)) dut_s4 (
        .clk(clk), .rst(rst),
        .req0_valid(q_req0_valid), .req0_ready(q_req0_ready), .req0_type(q_req0_type),
        .req0_amt(q_req0_amt), .req0_data(q_req0_data),
        .req1_valid(q_req1_valid), .req1_ready(q_req1_ready), .req1_type(q_req1_type),
        .req1_amt(q_req1_amt), .req1_data(q_req1_data),
        .rsp_valid(q_rsp_valid), .rsp_ready(q_rsp_ready), .rsp_id(q_rsp_id),
        .rsp_data(q_rsp_data), .busy(q_busy)
    );

    // ---------------------------------------------------------------- helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference shift: apply the single-position rule amt times.
    function automatic logic [31:0] shift_ref(input logic [1:0] t, input logic [31:0] d, input int amt);
        logic [31:0] v;
        logic        msb;
        v   = d;
        msb = d[31];
        for (int i = 0; i < amt; i++) begin
            case (t)
                SH_LSL:  v = {v[30:0], 1'b0};
                SH_LSR:  v = {1'b0, v[31:1]};
                SH_ASR:  v = {msb, v[31:1]};
                default: v = {v[0], v[31:1]};
            endcase
        end
        return v;
    endfunction

    function automatic int exp_latency(input int amt, input int step);
        if (amt == 0) return 1;
        if (BARREL) return 2;
        return 1 + (amt + step - 1) / step;
    endfunction

    function automatic logic [4:0] rand_amt();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 5'd0;
        if (r == 1) return 5'd31;
        return 5'($urandom_range(1, 30));
    endfunction

    // ------------------------------------------------------------------ model
    typedef enum int {M_IDLE, M_WAIT, M_RESP} mphase_t;
    mphase_t     m_phase = M_IDLE;
    logic        m_ptr   = 1'b0;
    int          m_wait  = 0;
    logic        m_id    = 1'b0;
    logic [31:0] m_data  = '0;
    logic        m_g;
    logic        e_r0, e_r1, e_g;
    bit          chk_en  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = M_IDLE;
            m_ptr   = 1'b0;
            m_wait  = 0;
        end else begin
            case (m_phase)
                M_IDLE: if (req0_valid || req1_valid) begin
                    m_g    = (req0_valid && req1_valid) ? m_ptr : req1_valid;
                    m_id   = m_g;
                    m_data = m_g ? shift_ref(req1_type, req1_data, int'(req1_amt))
                                 : shift_ref(req0_type, req0_data, int'(req0_amt));
                    m_wait = exp_latency(m_g ? int'(req1_amt) : int'(req0_amt), TB_STEP) - 1;
                    m_ptr  = ~m_g;
                    m_phase = (m_wait == 0) ? M_RESP : M_WAIT;
                end
                M_WAIT: begin
                    m_wait--;
                    if (m_wait == 0) m_phase = M_RESP;
                end
                default: if (rsp_ready) m_phase = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            e_r0 = 1'b0;
            e_r1 = 1'b0;
            if (m_phase == M_IDLE && !rst && (req0_valid || req1_valid)) begin
                e_g  = (req0_valid && req1_valid) ? m_ptr : req1_valid;
                e_r0 = ~e_g;
                e_r1 = e_g;
            end
            check("req0_ready", req0_ready, e_r0);
            check("req1_ready", req1_ready, e_r1);
            check("busy", busy, m_phase != M_IDLE);
            check("rsp_valid", rsp_valid, m_phase == M_RESP);
            if (m_phase == M_RESP) begin
                check("rsp_id", rsp_id, m_id);
                check("rsp_data", rsp_data, m_data);
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ------------------------------------------------------------- sequences
    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            ok = !busy && !rsp_valid;
        end
        check("wait_idle", ok, 1);
        @(posedge clk); #1;
    endtask

    // One operation on one port with rsp_ready high; returns result and latency.
    task automatic do_op(input bit port, input logic [1:0] t, input logic [4:0] amt,
                         input logic [31:0] d, output logic [31:0] res,
                         output logic rid, output int lat);
        bit got;
        res = '0;
        rid = 1'b0;
        lat = 0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (port) begin
            req1_valid = 1'b1; req1_type = t; req1_amt = amt; req1_data = d;
        end else begin
            req0_valid = 1'b1; req0_type = t; req0_amt = amt; req0_data = d;
        end
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = port ? req1_ready : req0_ready;
        end
        check("op_accept", got, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        got = 1'b0;
        for (int n = 1; n < 200 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1; lat = n; res = rsp_data; rid = rsp_id;
            end
        end
        check("op_response", got, 1);
        @(posedge clk); #1;
    endtask

    logic [31:0] res;
    logic        rid;
    int          lat;
    bit          got;
    logic        g;

    initial begin
        // NOTE: stimulus is driven with blocking assignments 1 time unit after
        // the rising edge, so the DUT and the model see settled inputs.
        rst = 1'b1;
        rsp_ready = 1'b1;
        req0_valid = 0; req0_type = 0; req0_amt = 0; req0_data = 0;
        req1_valid = 0; req1_type = 0; req1_amt = 0; req1_data = 0;
        q_req0_valid = 0; q_req0_type = 0; q_req0_amt = 0; q_req0_data = 0;
        q_req1_valid = 0; q_req1_type = 0; q_req1_amt = 0; q_req1_data = 0;
        q_rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_rsp_data", rsp_data, 32'h0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_busy", busy, 0);
        @(posedge clk); #1;

        // Both requesters valid continuously: grants must alternate 0,1,0,1
        req0_valid = 1; req0_type = SH_LSL; req0_amt = 5'd2; req0_data = 32'h0000_0003;
        req1_valid = 1; req1_type = SH_LSR; req1_amt = 5'd2; req1_data = 32'hC000_0000;
        for (int i = 0; i < 4; i++) begin
            got = 1'b0;
            g   = 1'b0;
            for (int n = 0; n < 100 && !got; n++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    got = 1'b1;
                    g   = req1_ready;
                end
            end
            check("arb_accept", got, 1);
            check("arb_grant", g, i % 2);
            @(posedge clk); #1;
        end
        req0_valid = 0; req1_valid = 0;
        wait_idle();

        // Directed operations
        do_op(1'b0, SH_LSL, 5'd4, 32'h0000_0001, res, rid, lat);
        check("lsl4_data", res, 32'h0000_0010);
        check("lsl4_id", rid, 0);
        check("lsl4_latency", lat, BARREL ? 2 : 5);

        do_op(1'b1, SH_ASR, 5'd31, 32'h8000_0000, res, rid, lat);
        check("asr31_data", res, 32'hFFFF_FFFF);
        check("asr31_id", rid, 1);
        check("asr31_latency", lat, BARREL ? 2 : 32);

        do_op(1'b1, SH_LSR, 5'd31, 32'h8000_0000, res, rid, lat);
        check("lsr31_data", res, 32'h0000_0001);

        do_op(1'b0, SH_ROR, 5'd1, 32'h0000_0001, res, rid, lat);
        check("ror1_data", res, 32'h8000_0000);
        check("ror1_latency", lat, 2);

        for (int t = 0; t < 4; t++) begin
            do_op(t[0], 2'(t), 5'd0, 32'h1234_5678, res, rid, lat);
            check("amt0_data", res, 32'h1234_5678);
            check("amt0_latency", lat, 1);
        end

        // Back-pressure in DONE
        rsp_ready = 1'b0;
        req0_valid = 1; req0_type = SH_ROR; req0_amt = 5'd3; req0_data = 32'h0000_00F1;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = req0_ready;
        end
        check("bp_accept", got, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 1; req1_type = SH_LSL; req1_amt = 5'd1; req1_data = 32'h5;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = rsp_valid;
        end
        check("bp_response", got, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_data", rsp_data, 32'h2000_001E);
            check("bp_no_ready", req1_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_handshake_no_ready", req1_ready, 0);
        @(negedge clk);
        check("bp_next_accept", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 0;
        wait_idle();

        // Reset in the middle of a long shift
        req0_valid = 1; req0_type = SH_LSL; req0_amt = 5'd20; req0_data = 32'h0000_0ABC;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = req0_ready;
        end
        check("rst_accept", got, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_rsp_data", rsp_data, 32'h0);
        check("abort_rsp_id", rsp_id, 0);
        check("abort_ready0", req0_ready, 0);
        check("abort_ready1", req1_ready, 0);
        repeat (25) @(negedge clk);
        check("abort_no_response", rsp_valid, 0);
        @(posedge clk); #1;
        req0_valid = 1; req0_amt = 5'd1;
        req1_valid = 1; req1_amt = 5'd1;
        got = 1'b0;
        g   = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                got = 1'b1;
                g   = req1_ready;
            end
        end
        check("post_reset_grant", g, 0);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        wait_idle();

        // STEP=4 instance: LSR 0xF0000000 by 13
        q_req0_valid = 1; q_req0_type = SH_LSR; q_req0_amt = 5'd13; q_req0_data = 32'hF000_0000;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = q_req0_ready;
        end
        check("s4_accept", got, 1);
        @(posedge clk); #1;
        q_req0_valid = 0;
        got = 1'b0;
        lat = 0;
        for (int n = 1; n < 50 && !got; n++) begin
            @(negedge clk);
            if (q_rsp_valid) begin
                got = 1'b1; lat = n; res = q_rsp_data;
            end
        end
        check("s4_response", got, 1);
        check("s4_data", res, 32'h0007_8000);
        check("s4_latency", lat, BARREL ? 2 : 5);
        @(posedge clk); #1;

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req0_type  = 2'($urandom_range(0, 3));
            req0_amt   = rand_amt();
            req0_data  = $urandom;
            req1_valid = ($urandom_range(0, 2) != 0);
            req1_type  = 2'($urandom_range(0, 3));
            req1_amt   = rand_amt();
            req1_data  = $urandom;
            rsp_ready  = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 399) == 0);
            @(posedge clk); #1;
        end
        rst = 0;
        req0_valid = 0;
        req1_valid = 0;
        rsp_ready  = 1;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
